// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/flush controller.
//   ADDR_WIDTH        : width of jump/redirect addresses
//   STOP / NOSTOP     : per-stage stall bit encoding
//   ZERO              : all-zero address
//   STG_PC .. STG_WB  : stage indices into stall vector
//   STALL_*           : stall vector patterns, one per request source
//   redir_state_t     : redirect tracker state (idle / redirect pending)
package pipe_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned NUM_STAGES = 6;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam logic [ADDR_WIDTH-1:0] ZERO = '0;

    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EXE = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;

    // Stall patterns: the requesting stage and everything upstream of it freeze.
    localparam logic [NUM_STAGES-1:0] STALL_MEM  = 6'b011111;
    localparam logic [NUM_STAGES-1:0] STALL_EXE  = 6'b001111;
    localparam logic [NUM_STAGES-1:0] STALL_ID   = 6'b000111;
    localparam logic [NUM_STAGES-1:0] STALL_IF   = 6'b000011;
    localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;

    typedef enum logic {
        REDIR_IDLE    = 1'b0,
        REDIR_PENDING = 1'b1
    } redir_state_t;

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Bus-wait watchdog: counts consecutive wait cycles and raises a sticky
// timeout once a wait persists past TIMEOUT_CYCLES-1 counted cycles.
//   clk_i      : clock
//   rst_i      : asynchronous active-low reset
//   wait_i     : bus wait asserted this cycle
//   timeout_o  : sticky timeout flag (registered)
module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic wait_i,
    output logic timeout_o
);

    localparam int unsigned WD_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_WIDTH-1:0] WD_MAX = WD_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WD_WIDTH-1:0] wd_cnt_q;
    logic [WD_WIDTH-1:0] wd_cnt_d;
    logic                timeout_q;
    logic                timeout_d;

    // Counter saturates at WD_MAX; a wait seen while saturated trips the flag.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (wait_i) begin
            if (wd_cnt_q == WD_MAX) begin
                timeout_d = STOP;
            end else begin
                wd_cnt_d = wd_cnt_q + WD_WIDTH'(1);
            end
        end else begin
            wd_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central hazard/flush controller for the 6-stage core (PC, IF, ID, EXE, MEM, WB).
//   clk_i, rst_i       : clock, asynchronous active-low reset
//   stallreq_*_i       : per-stage stall requests (IF bus, ID load-use, EXE busy, MEM bus)
//   jump_flag_i/addr_i : taken jump resolved in EXE and its target
//   stall_o            : per-stage freeze vector (combinational)
//   flush_jump_o       : flush IF/ID and ID/EXE this cycle (combinational)
//   pc_redirect_o      : PC loads pc_target_o at next edge (combinational)
//   pc_target_o        : redirect address (combinational)
//   bus_timeout_o      : sticky bus watchdog error (registered)
//   stall_cycles_o     : count of cycles with any stall bit set (registered)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallreq_if_i,
    input  logic                  stallreq_id_i,
    input  logic                  stallreq_exe_i,
    input  logic                  stallreq_mem_i,
    input  logic                  jump_flag_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic                  flush_jump_o,
    output logic                  pc_redirect_o,
    output logic [ADDR_WIDTH-1:0] pc_target_o,
    output logic                  bus_timeout_o,
    output logic [CNT_WIDTH-1:0]  stall_cycles_o
);

    redir_state_t          state_q;
    redir_state_t          state_d;
    logic [ADDR_WIDTH-1:0] tgt_q;
    logic [ADDR_WIDTH-1:0] tgt_d;
    logic [CNT_WIDTH-1:0]  stall_cnt_q;
    logic                  jump_acc;
    logic                  bus_wait;

    // EXE is frozen exactly when MEM or EXE requests a stall; deriving acceptance
    // from the requests directly keeps stall_o free of a combinational self-loop.
    assign jump_acc = jump_flag_i & ~(stallreq_mem_i | stallreq_exe_i);

    // Priority stall merge; a load-use stall is dropped when its instruction is flushed.
    always_comb begin
        stall_o = STALL_NONE;
        if (stallreq_mem_i) begin
            stall_o = STALL_MEM;
        end else if (stallreq_exe_i) begin
            stall_o = STALL_EXE;
        end else if (stallreq_id_i && !jump_acc) begin
            stall_o = STALL_ID;
        end else if (stallreq_if_i) begin
            stall_o = STALL_IF;
        end
    end

    // Redirect tracker: fire immediately if PC is free, else hold the newest target.
    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        flush_jump_o  = jump_acc;
        pc_redirect_o = 1'b0;
        pc_target_o   = tgt_q;
        if (jump_acc) begin
            if (stall_o[STG_PC] == NOSTOP) begin
                pc_redirect_o = 1'b1;
                pc_target_o   = jump_addr_i;
                state_d       = REDIR_IDLE;
            end else begin
                state_d = REDIR_PENDING;
                tgt_d   = jump_addr_i;
            end
        end else if (state_q == REDIR_PENDING && stall_o[STG_PC] == NOSTOP) begin
            pc_redirect_o = 1'b1;
            state_d       = REDIR_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= REDIR_IDLE;
            tgt_q   <= ZERO;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    // Stall-cycle performance counter, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else if (|stall_o) begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign bus_wait       = stallreq_if_i | stallreq_mem_i;

    stall_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_bus_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wait_i    (bus_wait),
        .timeout_o (bus_timeout_o)
    );

endmodule
